seg_led_static_drv: RTL and testbench

//  Tick consumer for the static 7-segment demo. Takes the single-cycle cnt_flag

---
 rtl/seg_led_static_drv.sv | 154 +++++++++++++++
 tb/tb_seg_led_static_drv.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_led_static_drv.sv
// -----------------------------------------------------------------------------
// seg_led_static_drv
//
// Consumes the single-cycle tick from the period timer and steps a 4-bit digit
// value on each tick. The value is decoded into a common-anode 7-segment
// pattern. Every digit is driven with the same pattern, so the display is
// static and there is no multiplexing. Hold and direction inputs control the
// count. A one-cycle carry pulse marks each wrap so that counters can be
// cascaded.
//
// Parameters
//   SEG_WIDTH  number of digit-select lines, all driven together
//   MAX_VAL    highest displayed value (1..15); the count wraps MAX_VAL <-> 0
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cnt_flag_i  tick from the period timer; it may stay high for many cycles
//   hold_i      1 = ignore ticks and freeze the value
//   down_i      0 = count up, 1 = count down (sampled in the tick cycle)
//   seg_sel_o   digit enables, active low
//   seg_led_o   segments {dp,g,f,e,d,c,b,a}, active low
//   value_o     current digit value
//   carry_o     one-cycle pulse after the value wraps
// -----------------------------------------------------------------------------
module seg_led_static_drv #(
    parameter int unsigned SEG_WIDTH = 6,
    parameter int unsigned MAX_VAL   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_flag_i,
    input  logic                 hold_i,
    input  logic                 down_i,
    output logic [SEG_WIDTH-1:0] seg_sel_o,
    output logic [7:0]           seg_led_o,
    output logic [3:0]           value_o,
    output logic                 carry_o
);

    localparam logic [3:0] MaxVal = MAX_VAL[3:0];

    typedef enum logic [0:0] {
        StBlank,
        StRun
    } state_e;

    // Common-anode decode. The dp bit (bit 7) is always off.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] pat;
        case (v)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            4'hA:    pat = 8'h88;
            4'hB:    pat = 8'h83;
            4'hC:    pat = 8'hC6;
            4'hD:    pat = 8'hA1;
            4'hE:    pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    state_e               state_q, state_d;
    logic [3:0]           value_q, value_d;
    logic                 flag_q;
    logic                 carry_q, carry_d;
    logic [SEG_WIDTH-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]           seg_led_q, seg_led_d;
    logic                 tick;
    logic                 step;

    // Rising-edge detect, so a flag that stays high produces exactly one tick.
    assign tick = cnt_flag_i & ~flag_q;
    assign step = tick & ~hold_i;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        carry_d = 1'b0;
        case (state_q)
            StBlank: begin
                // The first accepted tick only turns the display on.
                if (step) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (step) begin
                    if (down_i) begin
                        if (value_q == 4'd0) begin
                            value_d = MaxVal;
                            carry_d = 1'b1;
                        end else begin
                            value_d = value_q - 4'd1;
                        end
                    end else begin
                        // Compare explicitly instead of relying on 4-bit overflow.
                        if (value_q >= MaxVal) begin
                            value_d = 4'd0;
                            carry_d = 1'b1;
                        end else begin
                            value_d = value_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = StBlank;
        endcase
    end

    // The display registers follow state/value one cycle behind.
    always_comb begin
        if (state_q == StRun) begin
            seg_sel_d = '0;
            seg_led_d = seg_decode(value_q);
        end else begin
            seg_sel_d = '1;
            seg_led_d = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StBlank;
            value_q   <= 4'd0;
            flag_q    <= 1'b0;
            carry_q   <= 1'b0;
            seg_sel_q <= '1;
            seg_led_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            flag_q    <= cnt_flag_i;
            carry_q   <= carry_d;
            seg_sel_q <= seg_sel_d;
            seg_led_q <= seg_led_d;
        end
    end

    assign seg_sel_o = seg_sel_q;
    assign seg_led_o = seg_led_q;
    assign value_o   = value_q;
    assign carry_o   = carry_q;

endmodule

// File: tb/tb_seg_led_static_drv.sv
module tb_seg_led_static_drv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cnt_flag;
    logic       hold;
    logic       down;

    logic [5:0] seg_sel9, seg_sel15;
    logic [7:0] seg_led9, seg_led15;
    logic [3:0] value9, value15;
    logic       carry9, carry15;

    int checks = 0;
    int failures = 0;

    logic [7:0] dec_tab [16];

    always #5 clk = ~clk;

    seg_led_static_drv #(.SEG_WIDTH(6), .MAX_VAL(9)) dut9 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_flag_i (cnt_flag),
        .hold_i     (hold),
        .down_i     (down),
        .seg_sel_o  (seg_sel9),
        .seg_led_o  (seg_led9),
        .value_o    (value9),
        .carry_o    (carry9)
    );

    seg_led_static_drv #(.SEG_WIDTH(6), .MAX_VAL(15)) dut15 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_flag_i (cnt_flag),
        .hold_i     (hold),
        .down_i     (down),
        .seg_sel_o  (seg_sel15),
        .seg_led_o  (seg_led15),
        .value_o    (value15),
        .carry_o    (carry15)
    );

    // One-cycle tick. On return (negedge after the active edge), value/carry
    // have updated; the segment registers update one cycle later.
    task automatic pulse(input logic dn);
        @(negedge clk);
        down     = dn;
        cnt_flag = 1'b1;
        @(negedge clk);
        cnt_flag = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cnt_flag = 1'b0; hold = 1'b0; down = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (seg_sel9 !== 6'h3F) begin failures++;
            $display("FAIL reset_sel got %h expected 3f", seg_sel9); end
        checks++; if (seg_led9 !== 8'hFF) begin failures++;
            $display("FAIL reset_led got %h expected ff", seg_led9); end
        checks++; if (value9 !== 4'd0 || carry9 !== 1'b0) begin failures++;
            $display("FAIL reset_val got %h/%b expected 0/0", value9, carry9); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (seg_sel9 !== 6'h3F || seg_led9 !== 8'hFF) begin failures++;
            $display("FAIL idle_blank got %h/%h expected 3f/ff", seg_sel9, seg_led9); end
        pulse(1'b0);
        checks++; if (value9 !== 4'd0 || carry9 !== 1'b0) begin failures++;
            $display("FAIL first_tick_val got %h/%b expected 0/0", value9, carry9); end
        @(negedge clk);
        checks++; if (seg_sel9 !== 6'h00 || seg_led9 !== 8'hC0) begin failures++;
            $display("FAIL first_tick_disp got %h/%h expected 00/c0", seg_sel9, seg_led9); end
    endtask

    task automatic test_up_count();
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] exp_v;
            exp_v = 4'(i % 10);
            pulse(1'b0);
            checks++; if (value9 !== exp_v || carry9 !== (i == 10)) begin failures++;
                $display("FAIL up_val[%0d] got %h/%b expected %h/%b",
                         i, value9, carry9, exp_v, (i == 10)); end
            @(negedge clk);
            checks++; if (seg_led9 !== dec_tab[exp_v] || carry9 !== 1'b0) begin failures++;
                $display("FAIL up_led[%0d] got %h/%b expected %h/0",
                         i, seg_led9, carry9, dec_tab[exp_v]); end
        end
    endtask

    task automatic test_down_count();
        pulse(1'b1);
        checks++; if (value9 !== 4'd9 || carry9 !== 1'b1) begin failures++;
            $display("FAIL down_wrap got %h/%b expected 9/1", value9, carry9); end
        @(negedge clk);
        checks++; if (seg_led9 !== 8'h90 || carry9 !== 1'b0) begin failures++;
            $display("FAIL down_wrap_led got %h/%b expected 90/0", seg_led9, carry9); end
        pulse(1'b1);
        @(negedge clk);
        checks++; if (value9 !== 4'd8 || seg_led9 !== 8'h80) begin failures++;
            $display("FAIL down_step got %h/%h expected 8/80", value9, seg_led9); end
    endtask

    task automatic test_stuck_flag();
        @(negedge clk);
        down = 1'b0;
        cnt_flag = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (value9 !== 4'd9 || carry9 !== 1'b0) begin failures++;
            $display("FAIL stuck_one_step got %h/%b expected 9/0", value9, carry9); end
        cnt_flag = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (value9 !== 4'd9) begin failures++;
            $display("FAIL stuck_drop got %h expected 9", value9); end
        pulse(1'b0);
        checks++; if (value9 !== 4'd0 || carry9 !== 1'b1) begin failures++;
            $display("FAIL stuck_reraise got %h/%b expected 0/1", value9, carry9); end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0);
            checks++; if (value9 !== 4'd0 || carry9 !== 1'b0) begin failures++;
                $display("FAIL hold[%0d] got %h/%b expected 0/0", i, value9, carry9); end
        end
        hold = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (value9 !== 4'd0) begin failures++;
            $display("FAIL hold_no_catchup got %h expected 0", value9); end
        pulse(1'b0);
        @(negedge clk);
        checks++; if (value9 !== 4'd1 || seg_led9 !== 8'hF9) begin failures++;
            $display("FAIL hold_release got %h/%h expected 1/f9", value9, seg_led9); end
    endtask

    task automatic test_max15_and_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b0); // enter RUN
        for (int i = 1; i <= 15; i++) pulse(1'b0);
        checks++; if (value15 !== 4'hF || carry15 !== 1'b0) begin failures++;
            $display("FAIL m15_top got %h/%b expected f/0", value15, carry15); end
        @(negedge clk);
        checks++; if (seg_led15 !== 8'h8E) begin failures++;
            $display("FAIL m15_led got %h expected 8e", seg_led15); end
        pulse(1'b0);
        checks++; if (value15 !== 4'h0 || carry15 !== 1'b1) begin failures++;
            $display("FAIL m15_wrap got %h/%b expected 0/1", value15, carry15); end
        for (int i = 1; i <= 7; i++) pulse(1'b0);
        @(negedge clk);
        checks++; if (value15 !== 4'd7 || seg_led15 !== 8'hF8) begin failures++;
            $display("FAIL m15_seven got %h/%h expected 7/f8", value15, seg_led15); end
        // Assert reset between edges; the outputs must blank without a clock.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg_sel15 !== 6'h3F || seg_led15 !== 8'hFF) begin failures++;
            $display("FAIL async_rst_disp got %h/%h expected 3f/ff", seg_sel15, seg_led15); end
        checks++; if (value15 !== 4'd0 || carry15 !== 1'b0) begin failures++;
            $display("FAIL async_rst_val got %h/%b expected 0/0", value15, carry15); end
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b0);
        checks++; if (value15 !== 4'd0) begin failures++;
            $display("FAIL rerun_val got %h expected 0", value15); end
        @(negedge clk);
        checks++; if (seg_sel15 !== 6'h00 || seg_led15 !== 8'hC0) begin failures++;
            $display("FAIL rerun_disp got %h/%h expected 00/c0", seg_sel15, seg_led15); end
    endtask

    initial begin
        dec_tab[0]  = 8'hC0; dec_tab[1]  = 8'hF9; dec_tab[2]  = 8'hA4; dec_tab[3]  = 8'hB0;
        dec_tab[4]  = 8'h99; dec_tab[5]  = 8'h92; dec_tab[6]  = 8'h82; dec_tab[7]  = 8'hF8;
        dec_tab[8]  = 8'h80; dec_tab[9]  = 8'h90; dec_tab[10] = 8'h88; dec_tab[11] = 8'h83;
        dec_tab[12] = 8'hC6; dec_tab[13] = 8'hA1; dec_tab[14] = 8'h86; dec_tab[15] = 8'h8E;
        test_reset();
        test_up_count();
        test_down_count();
        test_stuck_flag();
        test_hold();
        test_max15_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
